// File: rtl/miner_core_scheduler.sv
// Round-robin scheduler that shares one mining core between NUM_REQ requesters.
// It loads the winner's job into the core, returns the result with an ack pulse and aborts hung jobs.
module miner_core_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int IN_WORDS       = 20,
   parameter int OUT_WORDS      = 8,
   parameter int WORD_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                   aclk,
   input  logic                                   aresetn,
   output logic                                   busy,
   output logic [15:0]                            jobs_done,
   input  logic [NUM_REQ-1:0]                     req,
   input  logic [NUM_REQ*IN_WORDS*WORD_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                     grant,
   output logic [NUM_REQ-1:0]                     ack,
   output logic [OUT_WORDS*WORD_WIDTH-1:0]        result_data,
   output logic                                   result_timeout,
   output logic                                   core_en,
   output logic [IN_WORDS*WORD_WIDTH-1:0]         core_in_fifo,
   input  logic [OUT_WORDS*WORD_WIDTH-1:0]        core_out_fifo,
   input  logic                                   core_done,
   output logic                                   core_reset
);
   localparam int IN_BITS  = IN_WORDS * WORD_WIDTH;
   localparam int OUT_BITS = OUT_WORDS * WORD_WIDTH;
   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_ABORT = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    last_q;
   logic [IDX_W-1:0]    win_s;
   logic                win_valid_s;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [15:0]         jobs_done_q;
   logic [15:0]         jobs_done_d;
   logic [IN_BITS-1:0]  core_in_fifo_q;
   logic [IN_BITS-1:0]  sel_data_s;
   logic [OUT_BITS-1:0] result_data_q;
   logic                result_timeout_q;

   // Round-robin winner: first pending requester searching upward from last+1.
   always_comb begin
      win_s       = last_q;
      win_valid_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int               cand;
         logic [IDX_W-1:0] cand_idx;
         cand     = (int'(last_q) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_valid_s && req[cand_idx]) begin
            win_s       = cand_idx;
            win_valid_s = 1'b1;
         end else begin
            win_s       = win_s;
         end
      end
   end

   assign sel_data_s  = req_data[int'(idx_q)*IN_BITS +: IN_BITS];
   assign cnt_d       = cnt_q + CNT_W'(1);
   assign jobs_done_d = jobs_done_q + 16'd1;

   // Scheduler FSM with its job, result and bookkeeping registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         last_q           <= LAST_RST;
         cnt_q            <= '0;
         jobs_done_q      <= 16'd0;
         core_in_fifo_q   <= '0;
         result_data_q    <= '0;
         result_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_valid_s) begin
                  idx_q   <= win_s;
                  state_q <= S_LOAD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (req[idx_q]) begin
                  core_in_fifo_q <= sel_data_s;
                  cnt_q          <= '0;
                  state_q        <= S_RUN;
               end else begin
                  state_q        <= S_IDLE;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_d;
               // A done arriving in the last watchdog cycle still counts as a normal completion.
               if (core_done) begin
                  result_data_q    <= core_out_fifo;
                  result_timeout_q <= 1'b0;
                  state_q          <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  state_q          <= S_ABORT;
               end else begin
                  state_q          <= S_RUN;
               end
            end
            S_ABORT: begin
               result_data_q    <= '0;
               result_timeout_q <= 1'b1;
               state_q          <= S_RESP;
            end
            S_RESP: begin
               last_q  <= idx_q;
               if (!result_timeout_q) begin
                  jobs_done_q <= jobs_done_d;
               end else begin
                  jobs_done_q <= jobs_done_q;
               end
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Per-requester strobes decoded from state and owner index only.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = (state_q == S_LOAD) && (idx_q == IDX_W'(i));
         ack[i]   = (state_q == S_RESP) && (idx_q == IDX_W'(i));
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign core_en        = (state_q == S_RUN);
   assign core_reset     = !aresetn || (state_q == S_ABORT);
   assign jobs_done      = jobs_done_q;
   assign core_in_fifo   = core_in_fifo_q;
   assign result_data    = result_data_q;
   assign result_timeout = result_timeout_q;

endmodule

// File: tb/tb_miner_core_scheduler.sv
// Directed-sequence bench for miner_core_scheduler with randomized job/result words
// and an arbitration/bookkeeping reference model.
module tb_miner_core_scheduler;
   localparam int NR = 2;
   localparam int IW = 20;
   localparam int OW = 8;
   localparam int WW = 32;
   localparam int TO = 16;
   localparam int IB = IW * WW;
   localparam int OB = OW * WW;

   logic          aclk;
   logic          aresetn;
   logic          busy;
   logic [15:0]   jobs_done;
   logic [NR-1:0] req;
   logic [NR*IB-1:0] req_data;
   logic [NR-1:0] grant;
   logic [NR-1:0] ack;
   logic [OB-1:0] result_data;
   logic          result_timeout;
   logic          core_en;
   logic [IB-1:0] core_in_fifo;
   logic [OB-1:0] core_out_fifo;
   logic          core_done;
   logic          core_reset;

   int          n_vec;
   int          n_err;
   int          m_last;
   logic [15:0] m_jobs;

   miner_core_scheduler #(
      .NUM_REQ(NR), .IN_WORDS(IW), .OUT_WORDS(OW), .WORD_WIDTH(WW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .busy(busy), .jobs_done(jobs_done),
      .req(req), .req_data(req_data), .grant(grant), .ack(ack),
      .result_data(result_data), .result_timeout(result_timeout),
      .core_en(core_en), .core_in_fifo(core_in_fifo), .core_out_fifo(core_out_fifo),
      .core_done(core_done), .core_reset(core_reset)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Next owner under round-robin: first pending requester after the last one served.
   function automatic int rr_pick(input logic [NR-1:0] r, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (r[(last + k) % NR]) return (last + k) % NR;
      end
      return 0;
   endfunction

   function automatic logic [OB-1:0] rand_result();
      logic [OB-1:0] v;
      for (int j = 0; j < OW; j++) v[j*WW +: WW] = $urandom();
      return v;
   endfunction

   task automatic fill(input int who);
      for (int j = 0; j < IW; j++) req_data[who*IB + j*WW +: WW] = $urandom();
   endtask

   // One job from IDLE; lat = RUN cycles until done, 0 = core never finishes.
   task automatic serve(input int lat, input bit drop);
      int            idx;
      int            en_cnt;
      int            w;
      logic [OB-1:0] exp_res;
      logic          exp_to;
      idx = rr_pick(req, m_last);
      w = 0;
      do begin
         @(negedge aclk);
         w++;
      end while (grant == '0 && w < 20);
      chk("grant", grant, NR'(1) << idx);
      @(negedge aclk);
      chk("grant_one_cycle", grant, '0);
      chk("core_en_start", core_en, 1'b1);
      chk("core_in_fifo", core_in_fifo, req_data[idx*IB +: IB]);
      if (drop) req[idx] = 1'b0;
      en_cnt = 1;
      if (lat > 0) begin
         while (en_cnt < lat) begin
            @(negedge aclk);
            chk("core_en_run", core_en, 1'b1);
            en_cnt++;
         end
         exp_res       = rand_result();
         core_out_fifo = exp_res;
         core_done     = 1'b1;
         @(negedge aclk);
         core_done     = 1'b0;
         core_out_fifo = rand_result();
         exp_to        = 1'b0;
         m_jobs        = m_jobs + 16'd1;
      end else begin
         w = 0;
         do begin
            @(negedge aclk);
            w++;
            if (core_en) en_cnt++;
         end while (core_en && w < TO + 4);
         chk("timeout_en_cycles", en_cnt, TO);
         chk("abort_core_reset", core_reset, 1'b1);
         @(negedge aclk);
         exp_res = '0;
         exp_to  = 1'b1;
      end
      chk("ack", ack, NR'(1) << idx);
      chk("result_data", result_data, exp_res);
      chk("result_timeout", result_timeout, exp_to);
      chk("resp_core_en", core_en, 1'b0);
      chk("resp_core_reset", core_reset, 1'b0);
      m_last = idx;
      @(negedge aclk);
      chk("ack_one_cycle", ack, '0);
      chk("jobs_done", jobs_done, m_jobs);
   endtask

   initial begin
      int w;
      n_vec         = 0;
      n_err         = 0;
      m_last        = NR - 1;
      m_jobs        = 16'd0;
      aresetn       = 1'b0;
      req           = '0;
      req_data      = '0;
      core_done     = 1'b0;
      core_out_fifo = '0;
      #1;
      chk("rst_core_reset", core_reset, 1'b1);
      repeat (2) @(negedge aclk);
      chk("rst_grant", grant, '0);
      chk("rst_ack", ack, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_core_en", core_en, 1'b0);
      chk("rst_jobs_done", jobs_done, 16'd0);
      chk("rst_result", result_data, '0);
      chk("rst_result_timeout", result_timeout, 1'b0);
      chk("rst_core_in_fifo", core_in_fifo, '0);
      aresetn = 1'b1;
      #1;
      chk("run_core_reset", core_reset, 1'b0);

      // Single request with known header words.
      for (int j = 0; j < IW; j++) req_data[j*WW +: WW] = 32'h1000 + j;
      req = 2'b01;
      serve(10, 1'b1);
      chk("in_word5", core_in_fifo[5*WW +: WW], 32'h1005);

      // Fairness with both requesters held high.
      fill(0);
      fill(1);
      req = 2'b11;
      for (int n = 0; n < 4; n++) serve($urandom_range(1, TO - 1), 1'b0);
      req = '0;

      // Watchdog abort.
      fill(0);
      req = 2'b01;
      serve(0, 1'b1);

      // Done in the final watchdog cycle.
      fill(1);
      req = 2'b10;
      serve(TO, 1'b1);

      // Withdrawn request leaves the arbitration pointer untouched.
      fill(0);
      req = 2'b01;
      serve(3, 1'b1);
      fill(1);
      req = 2'b11;
      w = 0;
      do begin
         @(negedge aclk);
         w++;
      end while (grant == '0 && w < 20);
      chk("wd_grant", grant, NR'(1) << rr_pick(req, m_last));
      req = '0;
      @(negedge aclk);
      chk("wd_busy", busy, 1'b0);
      chk("wd_core_en", core_en, 1'b0);
      for (int n = 0; n < 3; n++) begin
         @(negedge aclk);
         chk("wd_no_ack", ack, '0);
      end
      req = 2'b11;
      serve($urandom_range(1, TO - 1), 1'b1);
      req = '0;

      // Asynchronous reset in the middle of a job.
      fill(0);
      req = 2'b01;
      w = 0;
      do begin
         @(negedge aclk);
         w++;
      end while (grant == '0 && w < 20);
      repeat (3) @(negedge aclk);
      req = '0;
      chk("mid_core_en", core_en, 1'b1);
      #2 aresetn = 1'b0;
      #1;
      chk("mid_rst_core_reset", core_reset, 1'b1);
      chk("mid_rst_core_en", core_en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ack", ack, '0);
      chk("mid_rst_jobs_done", jobs_done, 16'd0);
      chk("mid_rst_result", result_data, '0);
      chk("mid_rst_core_in_fifo", core_in_fifo, '0);
      @(negedge aclk);
      aresetn = 1'b1;
      m_last  = NR - 1;
      m_jobs  = 16'd0;
      for (int n = 0; n < 3; n++) begin
         @(negedge aclk);
         chk("post_rst_ack", ack, '0);
      end
      fill(0);
      fill(1);
      req = 2'b11;
      serve($urandom_range(1, TO - 1), 1'b1);
      req = '0;

      // Completed-job counter wrap.
      force dut.jobs_done_q = 16'hFFFF;
      @(negedge aclk);
      release dut.jobs_done_q;
      m_jobs = 16'hFFFF;
      @(negedge aclk);
      chk("preset_jobs_done", jobs_done, 16'hFFFF);
      fill(1);
      req = 2'b10;
      serve(4, 1'b1);
      chk("wrap_jobs_done", jobs_done, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
